// File: rtl/message_receiver.sv
// Serial frame receiver: start bit, DATA_BITS data bits LSB first, one stop bit.
// The line is synchronised, then each bit is sampled at its centre; good frames update msg.
module message_receiver #(
    parameter int BIT_CYCLES = 1024,
    parameter int DATA_BITS  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] msg,
    output logic                 msg_valid,
    output logic                 frame_err,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [9:0] HALF_LAST = 10'(BIT_CYCLES / 2 - 1);
    localparam logic [9:0] BIT_LAST  = 10'(BIT_CYCLES - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);

    state_t               state_reg, state_next;
    logic [9:0]           cnt_reg, cnt_next;
    logic [3:0]           bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] msg_reg, msg_next;
    logic                 msg_valid_reg, msg_valid_next;
    logic                 frame_err_reg, frame_err_next;
    logic [1:0]           sync_reg;
    logic                 rx_s;

    assign rx_s = sync_reg[1];

    // Synchroniser flops reset high so an idle line never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], serial_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            msg_reg       <= '0;
            msg_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            msg_reg       <= msg_next;
            msg_valid_reg <= msg_valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        msg_next       = msg_reg;
        msg_valid_next = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 10'd1;
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    shift_next   = {rx_s, shift_reg} >> 1;
                    cnt_next     = '0;
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == DATA_LAST) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 10'd1;
                end
            end
            STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rx_s) begin
                        msg_next       = shift_reg;
                        msg_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 10'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign msg       = msg_reg;
    assign msg_valid = msg_valid_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_message_receiver.sv
// Self-checking bench for message_receiver: table vectors, hand-written corner
// sequences and randomized frames checked against a frame-level reference model.
module tb_message_receiver;
    localparam int B   = 16;
    localparam int D   = 6;
    localparam int LAT = 2 + B / 2 + (D + 1) * B;   // first low sample -> msg_valid edge
    localparam int REARM_PERIOD = 1 + B / 2 + (D + 1) * B; // line held low: error to error

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         serial_in = 1'b1;
    logic [D-1:0] msg;
    logic         msg_valid;
    logic         frame_err;
    logic         busy;

    message_receiver #(.BIT_CYCLES(B), .DATA_BITS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .msg       (msg),
        .msg_valid (msg_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Pulse monitor, sampled on the falling edge
    int           valid_t[$];
    logic [D-1:0] valid_m[$];
    int           err_t[$];
    logic [D-1:0] prev_msg = '0;

    always @(negedge clk) begin
        if (msg_valid) begin
            valid_t.push_back(cyc);
            valid_m.push_back(msg);
        end
        if (frame_err) err_t.push_back(cyc);
        if (msg_valid && frame_err) check("pulse_exclusive", 1, 0);
        if (!rst && !msg_valid && msg !== prev_msg)
            check("msg_stable", int'(msg), int'(prev_msg));
        prev_msg = msg;
    end

    task automatic clear_q();
        valid_t.delete();
        valid_m.delete();
        err_t.delete();
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one full frame; optional short inversions early in each bit, away from sample points
    task automatic send_frame(input logic [D-1:0] p, input logic stop, input bit glitch,
                              output int s);
        logic [D+1:0] bits;
        bits = {stop, p, 1'b0};
        s = 0;
        for (int j = 0; j < D + 2; j++) begin
            for (int k = 0; k < B; k++) begin
                @(negedge clk);
                if (j == 0 && k == 0) s = cyc + 1;
                serial_in = (glitch && (k == 2 || k == 3)) ? ~bits[j] : bits[j];
            end
        end
    endtask

    task automatic run_frame(input string name, input logic [D-1:0] p, input logic stop,
                             input bit glitch, input logic [D-1:0] exp_msg,
                             input int exp_nv, input int exp_ne);
        int s;
        clear_q();
        send_frame(p, stop, glitch, s);
        idle(2 * B);
        check({name, "_valid_cnt"}, valid_t.size(), exp_nv);
        check({name, "_err_cnt"}, err_t.size(), exp_ne);
        if (exp_nv == 1 && valid_t.size() == 1) begin
            check({name, "_valid_edge"}, valid_t[0], s + LAT);
            check({name, "_valid_msg"}, int'(valid_m[0]), int'(exp_msg));
        end
        if (exp_ne == 1 && err_t.size() == 1)
            check({name, "_err_edge"}, err_t[0], s + LAT);
        check({name, "_msg"}, int'(msg), int'(exp_msg));
        check({name, "_busy"}, int'(busy), 0);
        $display("frame %s: payload=%02h stop=%0d -> msg=%02h valids=%0d errs=%0d",
                 name, p, stop, msg, valid_t.size(), err_t.size());
    endtask

    typedef struct {
        logic [D-1:0] p;
        logic         stop;
        logic [D-1:0] exp_msg;
        int           exp_nv;
        int           exp_ne;
    } vec_t;

    vec_t         vecs[5];
    logic [D-1:0] ref_msg;

    initial begin
        int s, s1, s2, first, busy_cnt, busy_first;
        logic [D-1:0] rp;
        logic         rstop;
        bit           rgl;

        vecs[0] = '{6'h2D, 1'b1, 6'h2D, 1, 0};
        vecs[1] = '{6'h15, 1'b0, 6'h2D, 0, 1};
        vecs[2] = '{6'h00, 1'b1, 6'h00, 1, 0};
        vecs[3] = '{6'h3F, 1'b1, 6'h3F, 1, 0};
        vecs[4] = '{6'h2A, 1'b0, 6'h3F, 0, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_msg", int'(msg), 0);
        check("rst_valid", int'(msg_valid), 0);
        check("rst_err", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        idle(5);

        for (int i = 0; i < 5; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].p, vecs[i].stop, 1'b0,
                      vecs[i].exp_msg, vecs[i].exp_nv, vecs[i].exp_ne);
        ref_msg = 6'h3F;

        // Short low glitch on an idle line
        clear_q();
        @(negedge clk);
        serial_in = 1'b0;
        s = cyc + 1;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        busy_cnt = 0;
        busy_first = -1;
        for (int k = 0; k < 30; k++) begin
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = cyc;
            end
            @(negedge clk);
        end
        check("glitch_busy_cycles", busy_cnt, B / 2);
        check("glitch_busy_start", busy_first, s + 2);
        check("glitch_pulses", valid_t.size() + err_t.size(), 0);
        $display("glitch: busy for %0d cycles from edge %0d", busy_cnt, busy_first - s);

        // Reset during the third data bit
        clear_q();
        @(negedge clk);
        serial_in = 1'b0;
        repeat (B - 1) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            serial_in = 1'b1;
            repeat (B - 1) @(negedge clk);
        end
        @(negedge clk);
        serial_in = 1'b0;
        repeat (B / 2) @(negedge clk);
        check("midframe_busy", int'(busy), 1);
        #1 rst = 1'b1;
        #1;
        check("abort_msg", int'(msg), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_pulses", int'(msg_valid) + int'(frame_err), 0);
        @(negedge clk);
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2 * B);
        check("abort_no_pulse", valid_t.size() + err_t.size(), 0);
        check("abort_idle", int'(busy), 0);
        $display("reset mid-frame: msg=%02h busy=%0d", msg, busy);
        run_frame("after_rst", 6'h3F, 1'b1, 1'b0, 6'h3F, 1, 0);

        // Back-to-back frames
        clear_q();
        send_frame(6'h01, 1'b1, 1'b0, s1);
        send_frame(6'h3E, 1'b1, 1'b0, s2);
        idle(2 * B);
        check("b2b_cnt", valid_t.size(), 2);
        if (valid_t.size() == 2) begin
            check("b2b_edge0", valid_t[0], s1 + LAT);
            check("b2b_edge1", valid_t[1], s2 + LAT);
            check("b2b_spacing", valid_t[1] - valid_t[0], (D + 2) * B);
            check("b2b_msg0", int'(valid_m[0]), 6'h01);
            check("b2b_msg1", int'(valid_m[1]), 6'h3E);
        end
        ref_msg = 6'h3E;
        $display("back-to-back: %0d valids, msg=%02h", valid_t.size(), msg);

        // Randomized frames against the frame-level model
        for (int i = 0; i < 10; i++) begin
            rp    = D'($urandom_range(0, (1 << D) - 1));
            rstop = ($urandom_range(0, 3) != 0);
            rgl   = 1'($urandom_range(0, 1));
            if (rstop) ref_msg = rp;
            run_frame($sformatf("rnd%0d", i), rp, rstop, rgl, ref_msg,
                      int'(rstop), int'(!rstop));
        end

        // Line held low: repeated frame errors, never a valid
        clear_q();
        @(negedge clk);
        serial_in = 1'b0;
        s = cyc + 1;
        first = s + LAT;
        while (cyc < first + 2 * REARM_PERIOD) @(negedge clk);
        serial_in = 1'b1;
        repeat (2 * B) @(negedge clk);
        check("stuck_err_cnt", err_t.size(), 3);
        if (err_t.size() == 3) begin
            for (int k = 0; k < 3; k++)
                check($sformatf("stuck_err_edge%0d", k), err_t[k], first + k * REARM_PERIOD);
        end
        check("stuck_no_valid", valid_t.size(), 0);
        check("stuck_msg", int'(msg), int'(ref_msg));
        $display("stuck low: %0d frame errors, msg=%02h", err_t.size(), msg);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
